// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- bundle of every non-clock/non-reset signal of the fetch unit.
//
// master : the fetch unit itself (drives stall, if_*, mem_addr, mem_rd)
// slave  : the environment (PC register, decode stage and byte memory)
//
// Signals
//   rdy        global enable; 0 freezes the fetch unit
//   pc, pc_e   fetch address and its request strobe
//   jmp_e      redirect/flush; in-flight fetch is discarded
//   stall      back-pressure towards the PC register
//   if_inst    fetched instruction word
//   if_pc      address of if_inst
//   if_valid   if_inst/if_pc valid
//   if_stall   decode not accepting
//   mem_addr   byte read address
//   mem_rd     byte read request
//   mem_gnt    request accepted this cycle
//   mem_din    returned byte
//   mem_dvalid mem_din valid; bytes return in request order
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        rdy;
    logic [31:0] pc;
    logic        pc_e;
    logic        jmp_e;
    logic        stall;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_stall;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_gnt;
    logic [7:0]  mem_din;
    logic        mem_dvalid;

    modport master (
        input  rdy, pc, pc_e, jmp_e, if_stall, mem_gnt, mem_din, mem_dvalid,
        output stall, if_inst, if_pc, if_valid, mem_addr, mem_rd
    );

    modport slave (
        output rdy, pc, pc_e, jmp_e, if_stall, mem_gnt, mem_din, mem_dvalid,
        input  stall, if_inst, if_pc, if_valid, mem_addr, mem_rd
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch unit with a 16-entry direct-mapped icache in
// front of a byte-wide memory.
//
// A hit in IDLE presents the cached word on the next cycle. A miss latches the
// PC, issues four byte reads (pc+0..pc+3), assembles the returned bytes
// little-endian, fills the line and presents the word. jmp_e aborts any
// in-flight fetch; reads that were already granted are drained and dropped.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    if_fetch_if.master (PC side, decode side and memory side)
//
// Cache line n (n = pc[5:2]) keeps a valid bit and tag pc[31:6] in flops so
// the hit test is combinational; the data words live in a RAM array that is
// only read into the if_inst register.
// ---------------------------------------------------------------------------
module if_fetch (
    input  logic       clk,
    input  logic       rst_n,
    if_fetch_if.master bus
);
    localparam int unsigned LINES = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_fetch_pc;    // latched miss address
    logic [2:0]  r_issue_cnt;   // reads granted for this line, 0..4
    logic [1:0]  r_rx_cnt;      // bytes received for this line, 0..3
    logic [2:0]  r_out_cnt;     // granted minus returned, 0..4
    logic [23:0] r_word;        // low three bytes of the word being assembled

    logic        r_if_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;

    logic [31:0] r_line_data [LINES];

    logic [3:0]       w_idx;
    logic [25:0]      w_tag;
    logic [3:0]       w_fill_idx;
    logic [LINES-1:0] w_hit_vec;
    logic             w_hit;
    logic             w_stall;
    logic             w_accept;
    logic             w_accept_hit;
    logic             w_accept_miss;
    logic             w_mem_rd;
    logic             w_grant;
    logic             w_ret;
    logic             w_last_byte;
    logic             w_fill;
    logic [2:0]       w_out_next;
    logic [31:0]      w_full_word;
    logic             w_unused;

    // pc[1:0] is not part of the cache address; fetches are word aligned.
    assign w_unused = &{1'b0, bus.pc[1:0]};

    assign w_idx      = bus.pc[5:2];
    assign w_tag      = bus.pc[31:6];
    assign w_fill_idx = r_fetch_pc[5:2];

    // ------------------------------------------------------------------
    // Tag/valid store, one flop group per line.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            logic        r_valid;
            logic [25:0] r_tag;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                end else if (w_fill && (w_fill_idx == 4'(gi))) begin
                    r_valid <= 1'b1;
                    r_tag   <= r_fetch_pc[31:6];
                end
            end

            assign w_hit_vec[gi] = r_valid && (r_tag == w_tag);
        end
    endgenerate

    assign w_hit = w_hit_vec[w_idx];

    // Data words: written only on a completed, non-flushed fill.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_line_data[w_fill_idx] <= w_full_word;
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_stall       = (r_state != S_IDLE) || (r_if_valid && bus.if_stall);
    assign w_accept      = bus.rdy && bus.pc_e && !w_stall && !bus.jmp_e;
    assign w_accept_hit  = w_accept && w_hit;
    assign w_accept_miss = w_accept && !w_hit;

    // jmp_e removes the request in the same cycle so no new read is granted.
    assign w_mem_rd = bus.rdy && (r_state == S_FETCH) && (r_issue_cnt != 3'd4) && !bus.jmp_e;
    assign w_grant  = w_mem_rd && bus.mem_gnt;

    // Returns only count while reads are outstanding; stale bytes that arrive
    // after a reset find r_out_cnt == 0 and are ignored.
    assign w_ret       = bus.rdy && bus.mem_dvalid && (r_out_cnt != 3'd0);
    assign w_last_byte = (r_state == S_FETCH) && w_ret && (r_rx_cnt == 2'd3);
    assign w_fill      = w_last_byte && !bus.jmp_e;
    assign w_full_word = {bus.mem_din, r_word};
    assign w_out_next  = r_out_cnt + {2'd0, w_grant} - {2'd0, w_ret};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (bus.rdy) begin
            if (bus.jmp_e) begin
                w_state_next = (w_out_next != 3'd0) ? S_DRAIN : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept_miss) begin
                            w_state_next = S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (w_last_byte) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        if (w_out_next == 3'd0) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= '0;
            r_issue_cnt <= '0;
            r_rx_cnt    <= '0;
            r_out_cnt   <= '0;
            r_word      <= '0;
            r_if_valid  <= 1'b0;
            r_if_inst   <= '0;
            r_if_pc     <= '0;
        end else if (bus.rdy) begin
            r_state   <= w_state_next;
            r_out_cnt <= w_out_next;

            // Line-fill bookkeeping
            if (bus.jmp_e) begin
                r_issue_cnt <= '0;
                r_rx_cnt    <= '0;
            end else if (w_accept_miss) begin
                r_fetch_pc  <= bus.pc;
                r_issue_cnt <= '0;
                r_rx_cnt    <= '0;
            end else if (r_state == S_FETCH) begin
                if (w_grant) begin
                    r_issue_cnt <= r_issue_cnt + 3'd1;
                end
                if (w_ret) begin
                    r_rx_cnt <= r_rx_cnt + 2'd1;
                    case (r_rx_cnt)
                        2'd0:    r_word[7:0]   <= bus.mem_din;
                        2'd1:    r_word[15:8]  <= bus.mem_din;
                        2'd2:    r_word[23:16] <= bus.mem_din;
                        default: ; // byte 3 goes straight into w_full_word
                    endcase
                end
            end

            // Result towards decode: flush wins, then a new result, then
            // consumption; otherwise the result is held.
            if (bus.jmp_e) begin
                r_if_valid <= 1'b0;
            end else if (w_accept_hit) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= r_line_data[w_idx];
                r_if_pc    <= bus.pc;
            end else if (w_fill) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= w_full_word;
                r_if_pc    <= r_fetch_pc;
            end else if (r_if_valid && !bus.if_stall) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall    = w_stall;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_addr = r_fetch_pc + {29'd0, r_issue_cnt};
    assign bus.if_valid = r_if_valid;
    assign bus.if_inst  = r_if_inst;
    assign bus.if_pc    = r_if_pc;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- bench for if_fetch. A byte memory with randomised grant and
// return timing sits on the memory side; a transaction-level model (cache as
// tag/word tables, a fetch as "four returned bytes of word_at(pc)") predicts
// stall, mem_rd/mem_addr and the if_* result every cycle.
// ---------------------------------------------------------------------------
module tb_if_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    if_fetch_if bus ();

    if_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    // ---------------- memory slave ----------------
    logic [31:0] mq[$];     // granted, not yet returned addresses
    int gnt_mode = 2;       // 0 never, 1 always, 2 random
    int ret_mode = 2;

    // ---------------- reference model ----------------
    bit          m_busy, m_drain;
    logic [31:0] m_fpc;
    int          m_grants, m_rets, m_pend, m_orph;
    bit          m_cv [16];
    logic [25:0] m_ct [16];
    logic [31:0] m_cw [16];
    bit          exp_v;
    logic [31:0] exp_inst, exp_pc;

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_fpc = '0;
        m_grants = 0; m_rets = 0; m_pend = 0;
        for (int i = 0; i < 16; i++) m_cv[i] = 0;
        exp_v = 0; exp_inst = '0; exp_pc = '0;
    endtask

    // One clock cycle. Called at a negedge with the fetch-side inputs set.
    task automatic tick();
        bit          e_stall, e_rd, g, r, new_res;
        logic [3:0]  idx;
        bus.mem_gnt    = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 2) != 0);
        bus.mem_dvalid = bus.rdy && (mq.size() > 0) &&
                         (ret_mode == 1 || (ret_mode == 2 && $urandom_range(0, 1) == 1));
        bus.mem_din    = bus.mem_dvalid ? byte_at(mq[0]) : 8'($urandom);
        #1;
        e_stall = m_busy || m_drain || (exp_v && bus.if_stall);
        e_rd    = bus.rdy && m_busy && (m_grants < 4) && !bus.jmp_e;
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
        if (e_rd) check("mem_addr", bus.mem_addr, m_fpc + 32'(m_grants));
        #3;
        if (bus.mem_dvalid) mq.delete(0);
        if (bus.rdy && bus.mem_rd && bus.mem_gnt) mq.push_back(bus.mem_addr);
        if (bus.rdy) begin
            g = e_rd && bus.mem_gnt;
            r = bus.mem_dvalid;
            if (r && m_orph > 0) begin
                m_orph--;
                r = 0;
            end
            if (bus.jmp_e) begin
                exp_v = 0;
                if (m_busy || m_drain) begin
                    if (r) m_pend--;
                    m_busy  = 0;
                    m_drain = (m_pend > 0);
                end
            end else begin
                new_res = 0;
                if (m_busy) begin
                    if (g) begin m_grants++; m_pend++; end
                    if (r) begin m_rets++;   m_pend--; end
                    if (m_rets == 4) begin
                        idx       = m_fpc[5:2];
                        m_cv[idx] = 1;
                        m_ct[idx] = m_fpc[31:6];
                        m_cw[idx] = word_at(m_fpc);
                        exp_v     = 1;
                        exp_inst  = word_at(m_fpc);
                        exp_pc    = m_fpc;
                        m_busy    = 0;
                        new_res   = 1;
                    end
                end else if (m_drain) begin
                    if (r) m_pend--;
                    if (m_pend == 0) m_drain = 0;
                end else if (bus.pc_e && !e_stall) begin
                    idx = bus.pc[5:2];
                    if (m_cv[idx] && m_ct[idx] == bus.pc[31:6]) begin
                        exp_v    = 1;
                        exp_inst = m_cw[idx];
                        exp_pc   = bus.pc;
                        new_res  = 1;
                    end else begin
                        m_busy   = 1;
                        m_fpc    = bus.pc;
                        m_grants = 0;
                        m_rets   = 0;
                    end
                end
                if (!new_res && exp_v && !bus.if_stall) exp_v = 0;
            end
        end
        @(negedge clk);
        check("if_valid", 32'(bus.if_valid), 32'(exp_v));
        if (exp_v) begin
            check("if_inst", bus.if_inst, exp_inst);
            check("if_pc", bus.if_pc, exp_pc);
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while ((m_busy || m_drain) && n < max) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(m_busy || m_drain), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.pc   = a;
        bus.pc_e = 1'b1;
        tick();
        bus.pc_e = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; returns at a negedge.
    task automatic do_reset();
        bus.mem_gnt    = 1'b0;
        bus.mem_dvalid = 1'b0;
        #2 rst_n = 1'b0;
        m_orph = mq.size();
        model_reset();
        #1;
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rdy = 1'b1; bus.pc = '0; bus.pc_e = 1'b0; bus.jmp_e = 1'b0; bus.if_stall = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_din = '0; bus.mem_dvalid = 1'b0;
        m_orph = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        tick();

        // Cold miss at 0x100
        fetch(32'h100);
        check("cold_stall", 32'(bus.stall), 32'd1);
        wait_done("cold", 200);
        check("cold_inst", bus.if_inst, 32'h00100513);
        check("cold_pc", bus.if_pc, 32'h100);
        tick();

        // Hit on refetch
        fetch(32'h100);
        check("hit_valid", 32'(bus.if_valid), 32'd1);
        check("hit_inst", bus.if_inst, 32'h00100513);
        check("hit_stall", 32'(bus.stall), 32'd0);
        tick();

        // Conflict on index 0
        fetch(32'h140);
        check("conf_stall", 32'(bus.stall), 32'd1);
        wait_done("conf", 200);
        check("conf_inst", bus.if_inst, word_at(32'h140));
        tick();
        fetch(32'h100);
        check("remiss_stall", 32'(bus.stall), 32'd1);
        wait_done("remiss", 200);
        check("remiss_inst", bus.if_inst, 32'h00100513);
        tick();

        // Hold under if_stall with pc_e still asserted
        bus.if_stall = 1'b1;
        fetch(32'h100);
        bus.pc = 32'h140; bus.pc_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_inst", bus.if_inst, 32'h00100513);
            check("hold_stall", 32'(bus.stall), 32'd1);
        end
        bus.if_stall = 1'b0; bus.pc_e = 1'b0;
        tick();
        tick();

        // Flush after 2 grants / 1 return
        gnt_mode = 1; ret_mode = 0;
        fetch(32'h200);
        tick();
        tick();
        gnt_mode = 0; ret_mode = 1;
        tick();
        ret_mode = 0; bus.jmp_e = 1'b1;
        tick();
        bus.jmp_e = 1'b0;
        check("flush_drain_stall", 32'(bus.stall), 32'd1);
        check("flush_valid", 32'(bus.if_valid), 32'd0);
        ret_mode = 1;
        wait_done("flush", 50);
        check("flush_idle_stall", 32'(bus.stall), 32'd0);
        gnt_mode = 2; ret_mode = 2;
        fetch(32'h200);
        check("flush_nowrite", 32'(bus.stall), 32'd1);
        wait_done("flush_refill", 200);
        tick();

        // jmp_e coincident with the 4th byte
        gnt_mode = 1; ret_mode = 0;
        fetch(32'h244);
        for (int i = 0; i < 4; i++) tick();
        gnt_mode = 0; ret_mode = 1;
        for (int i = 0; i < 3; i++) tick();
        bus.jmp_e = 1'b1;
        tick();
        bus.jmp_e = 1'b0;
        check("race_valid", 32'(bus.if_valid), 32'd0);
        check("race_stall", 32'(bus.stall), 32'd0);
        gnt_mode = 2; ret_mode = 2;
        fetch(32'h244);
        check("race_nowrite", 32'(bus.stall), 32'd1);
        wait_done("race_refill", 200);
        tick();

        // rdy low for 5 cycles mid-fetch
        fetch(32'h304);
        tick();
        tick();
        bus.rdy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.rdy = 1'b1;
        wait_done("rdy", 200);
        check("rdy_inst", bus.if_inst, word_at(32'h304));
        tick();

        // Reset mid-fetch with reads outstanding
        gnt_mode = 1; ret_mode = 0;
        fetch(32'h380);
        tick();
        tick();
        do_reset();
        ret_mode = 1; gnt_mode = 2;
        for (int i = 0; i < 4; i++) tick();
        check("rst_orphans_valid", 32'(bus.if_valid), 32'd0);
        ret_mode = 2;
        fetch(32'h100);
        check("rst_cold_stall", 32'(bus.stall), 32'd1);
        wait_done("rst_cold", 200);
        check("rst_cold_inst", bus.if_inst, 32'h00100513);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.pc       = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2);
            bus.pc_e     = ($urandom_range(0, 1) == 1);
            bus.if_stall = ($urandom_range(0, 2) == 0);
            bus.jmp_e    = ($urandom_range(0, 19) == 0);
            bus.rdy      = ($urandom_range(0, 9) != 0);
            tick();
        end
        bus.pc_e = 1'b0; bus.jmp_e = 1'b0; bus.rdy = 1'b1; bus.if_stall = 1'b0;
        wait_done("rand_end", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
